// File: rtl/mem_access_stage_if.sv
// Bundle of the M-stage inputs, data-memory port, stall and MEM/WB outputs
// for the memory-access stage.
interface mem_access_stage_if;
  logic        validM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  logic        stallM;

  logic        validW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RdW;
  logic        faultW;

  modport slave (
    input  validM, RegWriteM, ResultSrcM, MemWriteM, funct3M, ALUResultM,
           WriteDataM, RdM, PCPlus4M, dmem_rdata, dmem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stallM,
           validW, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W,
           RdW, faultW
  );

  modport master (
    output validM, RegWriteM, ResultSrcM, MemWriteM, funct3M, ALUResultM,
           WriteDataM, RdM, PCPlus4M, dmem_rdata, dmem_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stallM,
           validW, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W,
           RdW, faultW
  );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V memory-access stage: byte-lane alignment, load extension, wait-state
// FSM with timeout, and the MEM/WB register (state updates on falling edge).
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  mem_access_stage_if.slave bus
);
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);
  localparam logic       TO_EN   = (TIMEOUT != 32'd0);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q, regwrite_q, fault_q;
  logic [1:0]  rsrc_q;
  logic [31:0] alu_q, rdata_q, pc4_q;
  logic [4:0]  rd_q;

  logic [1:0]  lane_s;
  logic        access_s, load_s, bad_s, good_s;
  logic        req_s, stall_s, abort_s, fault_s;
  logic [31:0] ext_s;

  function automatic logic f3_legal(input logic [2:0] f3, input logic store);
    case (f3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~store;
      default:                f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = 4'b0011 << a;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = rd;
    endcase
  endfunction

  assign lane_s   = bus.ALUResultM[1:0];
  assign access_s = bus.validM & (bus.MemWriteM | (bus.ResultSrcM == 2'b01));
  assign load_s   = (bus.ResultSrcM == 2'b01) & ~bus.MemWriteM;
  assign bad_s    = access_s & (~f3_legal(bus.funct3M, bus.MemWriteM)
                                | misaligned(bus.funct3M, lane_s));
  assign good_s   = access_s & ~bad_s;
  assign fault_s  = bad_s | abort_s;
  assign ext_s    = (load_s & good_s & ~abort_s)
                    ? load_ext(bus.funct3M, lane_s, bus.dmem_rdata) : 32'd0;

  // Wait-state FSM; in WAIT the M inputs are frozen by the stall, so the
  // dmem outputs derived from them stay stable without extra holding regs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_s   = 1'b0;
    stall_s = 1'b0;
    abort_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (good_s) begin
          req_s = 1'b1;
          if (!bus.dmem_ready) begin
            stall_s = 1'b1;
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        req_s = 1'b1;
        if (bus.dmem_ready) begin
          state_d = S_IDLE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          abort_s = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall_s = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register; a stall inserts a bubble while holding the datapath fields
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      fault_q    <= 1'b0;
      rsrc_q     <= 2'b00;
      alu_q      <= 32'd0;
      rdata_q    <= 32'd0;
      pc4_q      <= 32'd0;
      rd_q       <= 5'd0;
    end else if (stall_s) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      valid_q    <= bus.validM;
      regwrite_q <= bus.RegWriteM & bus.validM & ~fault_s;
      fault_q    <= fault_s;
      rsrc_q     <= bus.ResultSrcM;
      alu_q      <= bus.ALUResultM;
      rdata_q    <= ext_s;
      pc4_q      <= bus.PCPlus4M;
      rd_q       <= bus.RdM;
    end
  end

  assign bus.dmem_req   = reset & req_s;
  assign bus.dmem_we    = reset & req_s & bus.MemWriteM;
  assign bus.stallM     = reset & stall_s;
  assign bus.dmem_addr  = {bus.ALUResultM[31:2], 2'b00};
  assign bus.dmem_be    = load_s ? 4'b1111 : store_be(bus.funct3M, lane_s);
  assign bus.dmem_wdata = store_data(bus.funct3M, bus.WriteDataM);

  assign bus.validW     = valid_q;
  assign bus.RegWriteW  = regwrite_q;
  assign bus.ResultSrcW = rsrc_q;
  assign bus.ALUResultW = alu_q;
  assign bus.ReadDataW  = rdata_q;
  assign bus.PCPlus4W   = pc4_q;
  assign bus.RdW        = rd_q;
  assign bus.faultW     = fault_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage (TIMEOUT=4): vector table driven cycle by cycle,
// W-stage results checked through a scoreboard queue, plus reset sequences.
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage_if bus();
  mem_access_stage #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string       name;
    logic [1:0]  rs;
    logic        mw;
    logic        rwm;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          dly;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    int          e_stalls;
    logic        e_fault;
    logic        e_rw;
    logic        e_chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        fault;
    logic        chk_rd;
    logic [31:0] rdata;
  } wexp_t;

  vec_t  vecs[$];
  wexp_t exp_q[$];
  wexp_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [1:0] rs, input logic mw, input logic rwm,
                     input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rdata, input int dly, input logic e_req,
                     input logic [3:0] e_be, input logic [31:0] e_wdata, input int e_stalls,
                     input logic e_fault, input logic e_rw, input logic e_chk_rd,
                     input logic [31:0] e_rd);
    vec_t v;
    v = '{nm, rs, mw, rwm, f3, addr, wd, rdata, dly, e_req, e_be, e_wdata, e_stalls,
          e_fault, e_rw, e_chk_rd, e_rd};
    vecs.push_back(v);
  endtask

  // W-stage monitor: every valid W slot must match the oldest expectation
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      if (bus.validW === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got validW=1 want no pending result");
        end else begin
          e = exp_q.pop_front();
          chk("w_regwrite", 32'(bus.RegWriteW), 32'(e.rw));
          chk("w_resultsrc", 32'(bus.ResultSrcW), 32'(e.rs));
          chk("w_alu", bus.ALUResultW, e.alu);
          chk("w_pc4", bus.PCPlus4W, e.pc4);
          chk("w_rd", 32'(bus.RdW), 32'(e.rd));
          chk("w_fault", 32'(bus.faultW), 32'(e.fault));
          if (e.chk_rd) chk("w_readdata", bus.ReadDataW, e.rdata);
        end
      end else begin
        chk("bubble_regwrite", 32'(bus.RegWriteW), 32'd0);
        chk("bubble_fault", 32'(bus.faultW), 32'd0);
      end
    end
  end

  task automatic drive(input vec_t v, input int idx);
    bus.validM     = 1'b1;
    bus.RegWriteM  = v.rwm;
    bus.ResultSrcM = v.rs;
    bus.MemWriteM  = v.mw;
    bus.funct3M    = v.f3;
    bus.ALUResultM = v.addr;
    bus.WriteDataM = v.wd;
    bus.RdM        = 5'(idx + 5);
    bus.PCPlus4M   = 32'h1000 + 32'(idx * 4);
    bus.dmem_rdata = v.rdata;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wexp_t w;
    int    stalls;
    logic  st;
    logic  done;
    drive(v, idx);
    w = '{v.e_rw, v.rs, v.addr, 32'h1000 + 32'(idx * 4), 5'(idx + 5), v.e_fault,
          v.e_chk_rd, v.e_rd};
    exp_q.push_back(w);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.dmem_ready = (c == v.dly);
      #2;
      chk({v.name, "_req"}, 32'(bus.dmem_req), 32'(v.e_req));
      if (v.e_req) begin
        chk({v.name, "_we"}, 32'(bus.dmem_we), 32'(v.mw));
        chk({v.name, "_addr"}, bus.dmem_addr, v.addr & 32'hFFFF_FFFC);
        chk({v.name, "_be"}, 32'(bus.dmem_be), 32'(v.e_be));
        if (v.mw) chk({v.name, "_wdata"}, bus.dmem_wdata, v.e_wdata);
      end
      st = bus.stallM;
      @(negedge clk);
      #1;
      if (st !== 1'b1) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    chk({v.name, "_done"}, 32'(done), 32'd1);
    chk({v.name, "_stalls"}, 32'(stalls), 32'(v.e_stalls));
  endtask

  task automatic check_zero_w(input string nm);
    chk({nm, "_validW"}, 32'(bus.validW), 32'd0);
    chk({nm, "_regwrite"}, 32'(bus.RegWriteW), 32'd0);
    chk({nm, "_fault"}, 32'(bus.faultW), 32'd0);
    chk({nm, "_alu"}, bus.ALUResultW, 32'd0);
    chk({nm, "_readdata"}, bus.ReadDataW, 32'd0);
    chk({nm, "_pc4"}, bus.PCPlus4W, 32'd0);
    chk({nm, "_rd"}, 32'(bus.RdW), 32'd0);
    chk({nm, "_rs"}, 32'(bus.ResultSrcW), 32'd0);
    chk({nm, "_req"}, 32'(bus.dmem_req), 32'd0);
    chk({nm, "_we"}, 32'(bus.dmem_we), 32'd0);
    chk({nm, "_stall"}, 32'(bus.stallM), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time %0t want finish before 200000", $time);
    $fatal(1);
  end

  initial begin
    vec_t alu_v;
    vec_t ld_v;
    //   name    rs    mw    rwm   f3      addr          wd            rdata         dly
    //   req   be       wdata         stalls fault rw  chk  rd
    add("alu",  2'b00, 1'b0, 1'b1, 3'b000, 32'h0000_1234, 32'd0,        32'd0,        0,
        1'b0, 4'b0000, 32'd0,        0, 1'b0, 1'b1, 1'b1, 32'd0);
    add("lb",   2'b01, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'd0,        32'h80FF_1122, 0,
        1'b1, 4'b1111, 32'd0,        0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF80);
    add("lbu",  2'b01, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'd0,        32'h80FF_1122, 0,
        1'b1, 4'b1111, 32'd0,        0, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
    add("sh",   2'b00, 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'd0,       3,
        1'b1, 4'b1100, 32'hABCD_ABCD, 3, 1'b0, 1'b0, 1'b0, 32'd0);
    add("lwmis",2'b01, 1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'd0,        32'd0,        0,
        1'b0, 4'b0000, 32'd0,        0, 1'b1, 1'b0, 1'b0, 32'd0);
    add("ld011",2'b01, 1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'd0,        32'd0,        0,
        1'b0, 4'b0000, 32'd0,        0, 1'b1, 1'b0, 1'b0, 32'd0);
    add("lwto", 2'b01, 1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'd0,        32'd0,        99,
        1'b1, 4'b1111, 32'd0,        4, 1'b1, 1'b0, 1'b0, 32'd0);
    add("lwrdy4",2'b01,1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'd0,        32'hDEAD_BEEF, 4,
        1'b1, 4'b1111, 32'd0,        4, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    add("lh",   2'b01, 1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'd0,        32'h8001_7FFE, 1,
        1'b1, 4'b1111, 32'd0,        1, 1'b0, 1'b1, 1'b1, 32'hFFFF_8001);
    add("lhu",  2'b01, 1'b0, 1'b1, 3'b101, 32'h0000_0206, 32'd0,        32'h8001_7FFE, 0,
        1'b1, 4'b1111, 32'd0,        0, 1'b0, 1'b1, 1'b1, 32'h0000_8001);
    add("sb",   2'b00, 1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h1234_5678, 32'd0,       0,
        1'b1, 4'b0010, 32'h7878_7878, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    add("sw",   2'b00, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'd0,       2,
        1'b1, 4'b1111, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 1'b0, 32'd0);
    add("st011",2'b00, 1'b1, 1'b0, 3'b011, 32'h0000_0300, 32'hCAFE_F00D, 32'd0,       0,
        1'b0, 4'b0000, 32'd0,        0, 1'b1, 1'b0, 1'b0, 32'd0);
    add("pc4",  2'b10, 1'b0, 1'b1, 3'b000, 32'h0000_0055, 32'd0,        32'd0,        0,
        1'b0, 4'b0000, 32'd0,        0, 1'b0, 1'b1, 1'b1, 32'd0);
    add("lhmis",2'b01, 1'b0, 1'b1, 3'b001, 32'h0000_0103, 32'd0,        32'd0,        0,
        1'b0, 4'b0000, 32'd0,        0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Reset with a store presented: dmem strobes must stay low
    reset = 1'b0;
    drive(vecs[11], 0);
    bus.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_zero_w("rst");
    bus.validM = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("nonvalid_req", 32'(bus.dmem_req), 32'd0);
    bus.RegWriteM = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset pulse while the FSM is in WAIT
    ld_v = vecs[6];
    drive(ld_v, 40);
    bus.dmem_ready = 1'b0;
    #2;
    chk("midrst_stall0", 32'(bus.stallM), 32'd1);
    @(negedge clk);
    #3;
    chk("midrst_stall1", 32'(bus.stallM), 32'd1);
    chk("midrst_req1", 32'(bus.dmem_req), 32'd1);
    reset = 1'b0;
    #1;
    check_zero_w("midrst");
    exp_q.delete();
    bus.validM = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    alu_v = vecs[0];
    run_vec(alu_v, 41);
    ld_v = vecs[8];
    run_vec(ld_v, 42);

    bus.validM = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage of the 5-stage RISC-V pipeline, between the EX/MEM register and the writeback stage. Drives the data-memory port with byte-lane alignment, sign/zero-extends loads, and absorbs multi-cycle memory latency with a wait-state FSM that stalls upstream stages. Its registered outputs form the MEM/WB pipeline register, datapath and control, for the writeback stage.

Parameters:
TIMEOUT, 255, max wait cycles for dmem_ready before aborting the access; 0 disables the timeout (8-bit counter).

Ports:
clk  in  1  pipeline clock; all state updates on the falling edge.
reset  in  1  asynchronous, active-low reset.
validM  in  1  M-stage holds a live instruction.
RegWriteM  in  1  register-write enable.
ResultSrcM  in  2  writeback select: 00 ALU, 01 load data, 10 PC+4.
MemWriteM  in  1  store.
funct3M  in  3  access size/sign.
ALUResultM  in  32  effective address or ALU result.
WriteDataM  in  32  store data (rs2).
RdM  in  5  destination register.
PCPlus4M  in  32  PC+4.
dmem_req  out  1  memory request (combinational).
dmem_we  out  1  write strobe.
dmem_addr  out  32  {ALUResultM[31:2],2'b00}.
dmem_be  out  4  byte enables.
dmem_wdata  out  32  lane-replicated store data.
dmem_rdata  in  32  read word.
dmem_ready  in  1  access complete this cycle.
stallM  out  1  hold F/D/E/M stages (combinational).
validW, RegWriteW  out  1 each  registered.
ResultSrcW  out  2  registered.
ALUResultW, ReadDataW, PCPlus4W  out  32 each  registered; ReadDataW is extended load data.
RdW  out  5  registered.
faultW  out  1  registered; misaligned, illegal funct3, or timeout.

Behaviour:
- Access = validM & (MemWriteM | ResultSrcM==01). Load is ResultSrcM==01 & !MemWriteM.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Misaligned: half-word with addr[0]=1, or word with addr[1:0]≠00.
- Bad = illegal | misaligned. A bad access issues no dmem_req and no stall. Its W slot carries faultW=1 and RegWriteW=0.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{WD[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{WD[15:0]}}.
  - SW: be=1111, wdata=WD.
  - Loads: be=1111, we=0.
- Load extraction: byte/half selected by addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- FSM states: IDLE, WAIT.
  - IDLE, good access: dmem_req=1. If dmem_ready=1 the access completes this cycle (zero wait). Else stallM=1, counter cleared, next=WAIT.
  - WAIT: dmem_req=1 with all dmem_* outputs held stable (upstream is stalled, so M inputs are stable). dmem_ready=1 → complete, next=IDLE. Else counter+1.
  - WAIT timeout: when TIMEOUT≠0 and counter reaches TIMEOUT-1 without ready, abort → complete with faultW=1, RegWriteW=0, next=IDLE.
  - stallM=1 exactly when an access is in progress and not completing this cycle.
- W register update each falling edge:
  - stallM=1 → bubble: validW=0, RegWriteW=0, faultW=0; other W fields don't-care but held.
  - Otherwise → capture M fields, ReadDataW=extended data, validW=validM. Non-valid M forces RegWriteW=0.
- Simultaneous dmem_ready and timeout in the same cycle: ready wins, so the access completes normally.
- Non-access instructions pass through with 1-cycle latency; ReadDataW=0.
- Reset asserted:
  - All registered outputs 0, FSM=IDLE, counter 0.
  - dmem_req, dmem_we, stallM forced 0 combinationally.
  - Reset mid-WAIT abandons the access; no W write results.

Test Plan:
- Reset → all W outputs 0, dmem_req=0. Release reset; ALU op with ALUResultM=0x1234, Rd=5 → next edge RegWriteW=1, ALUResultW=0x1234, RdW=5, stallM never 1.
- LB addr 0x103, rdata=0x80FF_1122, ready same cycle → ReadDataW=0xFFFFFF80, no stall. Same with LBU → 0x00000080.
- SH addr 0x102, WD=0x0000ABCD, ready after 3 cycles → be=1100, wdata=0xABCDABCD held stable, stallM=1 for 3 cycles, three bubbles in W, then validW=1, RegWriteW=0.
- LW addr 0x101 → no dmem_req, faultW=1, RegWriteW=0, no stall. funct3=011 load → same response.
- TIMEOUT=4, load with ready held 0 → stallM=1 for 4 cycles, then faultW=1, FSM back to IDLE; ready arriving exactly on the 4th wait cycle → normal completion instead.
- Reset pulse during WAIT → outputs zero immediately; after release, next load starts from IDLE correctly.
